// File: rtl/wb_load_pipe_pkg.sv
// rtl/wb_load_pipe_pkg.sv - shared widths and load-mode constants for the write-back load path
package wb_load_pipe_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [1:0] LR_NONE  = 2'b00;
    localparam logic [1:0] LR_LEFT  = 2'b01;
    localparam logic [1:0] LR_RIGHT = 2'b10;

endpackage

// File: rtl/wb_load_pipe_if.sv
// rtl/wb_load_pipe_if.sv - MEM-stage to write-back bundle with pipeline control and register outputs
interface wb_load_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
);
    localparam int NB = DATA_W / 8;

    logic                  stall;
    logic                  flush;
    logic                  valid_in;
    logic [DATA_W-1:0]     ram_read_data;
    logic                  mem_read_flag;
    logic                  mem_write_flag;
    logic                  mem_sign_flag;
    logic [NB-1:0]         mem_sel;
    logic [1:0]            mem_lr_mode;
    logic [DATA_W-1:0]     result_in;
    logic [DATA_W-1:0]     reg_old_data;
    logic                  reg_write_en_in;
    logic [REG_ADDR_W-1:0] reg_write_addr_in;
    logic [ADDR_W-1:0]     current_pc_addr_in;

    logic                  valid_out;
    logic [DATA_W-1:0]     result_out;
    logic                  reg_write_en_out;
    logic [REG_ADDR_W-1:0] reg_write_addr_out;
    logic [ADDR_W-1:0]     debug_pc_addr_out;
    logic                  addr_error;
    logic [ADDR_W-1:0]     bad_addr;

    modport master (
        output stall, flush, valid_in, ram_read_data, mem_read_flag, mem_write_flag,
               mem_sign_flag, mem_sel, mem_lr_mode, result_in, reg_old_data,
               reg_write_en_in, reg_write_addr_in, current_pc_addr_in,
        input  valid_out, result_out, reg_write_en_out, reg_write_addr_out,
               debug_pc_addr_out, addr_error, bad_addr
    );

    modport slave (
        input  stall, flush, valid_in, ram_read_data, mem_read_flag, mem_write_flag,
               mem_sign_flag, mem_sel, mem_lr_mode, result_in, reg_old_data,
               reg_write_en_in, reg_write_addr_in, current_pc_addr_in,
        output valid_out, result_out, reg_write_en_out, reg_write_addr_out,
               debug_pc_addr_out, addr_error, bad_addr
    );

endinterface

// File: rtl/wb_load_pipe_load_align.sv
// rtl/wb_load_pipe_load_align.sv - combinational sub-word extract/extend, left/right merge and misalignment check
module load_align
    import wb_load_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   ram_read_data,
    input  logic [DATA_W-1:0]   reg_old_data,
    input  logic [DATA_W-1:0]   result_in,
    input  logic                mem_read_flag,
    input  logic                mem_write_flag,
    input  logic                mem_sign_flag,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [1:0]          mem_lr_mode,
    output logic [DATA_W-1:0]   wb_data,
    output logic                misaligned,
    output logic                write_ok
);
    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);

    logic [OFFW-1:0]   off;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] merged;
    logic              legal_sel;
    logic              sign_bit;
    logic              is_load;
    logic              is_normal;
    int                size;
    int                offi;

    assign off       = result_in[OFFW-1:0];
    assign is_load   = mem_read_flag & ~mem_write_flag;
    assign is_normal = (mem_lr_mode != LR_LEFT) && (mem_lr_mode != LR_RIGHT);

    always_comb begin
        offi      = int'(off);
        size      = 0;
        legal_sel = 1'b0;
        sign_bit  = 1'b0;
        ext       = '0;
        merged    = '0;
        for (int i = 0; i < NB; i++) size += int'(mem_sel[i]);
        for (int k = 1; k <= NB; k = k * 2)
            if (int'(mem_sel) == (1 << k) - 1) legal_sel = 1'b1;
        shifted = ram_read_data >> (8 * offi);
        for (int i = 0; i < NB; i++)
            if (i == size - 1) sign_bit = shifted[8*i+7];
        for (int i = 0; i < NB; i++)
            ext[8*i +: 8] = (i < size) ? shifted[8*i +: 8] : {8{mem_sign_flag & sign_bit}};
        // Left fills the top off+1 bytes from memory low bytes; right fills the low bytes from memory top bytes.
        for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = reg_old_data[8*i +: 8];
            if (mem_lr_mode == LR_LEFT && i >= NB - 1 - offi)
                merged[8*i +: 8] = ram_read_data[8*(i - (NB - 1 - offi)) +: 8];
            if (mem_lr_mode == LR_RIGHT && i <= NB - 1 - offi)
                merged[8*i +: 8] = ram_read_data[8*(i + offi) +: 8];
        end
    end

    assign misaligned = is_load & is_normal & (~legal_sel | ((offi & (size - 1)) != 0));
    assign write_ok   = ~mem_write_flag & ~misaligned;

    always_comb begin
        wb_data = result_in;
        if (mem_write_flag)  wb_data = '0;
        else if (is_load)    wb_data = misaligned ? '0 : (is_normal ? ext : merged);
    end

endmodule

// File: rtl/wb_load_pipe.sv
// rtl/wb_load_pipe.sv - write-back load stage: alignment logic plus one stall/flush pipeline register
module wb_load_pipe
    import wb_load_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input logic           clk,
    input logic           rst,
    wb_load_pipe_if.slave bus
);
    logic [DATA_W-1:0]     wb_data;
    logic                  misaligned;
    logic                  write_ok;
    logic                  err_next;
    logic [ADDR_W-1:0]     fault_addr;
    logic [REG_ADDR_W-1:0] dest_addr;

    load_align #(.DATA_W(DATA_W)) u_align (
        .ram_read_data  (bus.ram_read_data),
        .reg_old_data   (bus.reg_old_data),
        .result_in      (bus.result_in),
        .mem_read_flag  (bus.mem_read_flag),
        .mem_write_flag (bus.mem_write_flag),
        .mem_sign_flag  (bus.mem_sign_flag),
        .mem_sel        (bus.mem_sel),
        .mem_lr_mode    (bus.mem_lr_mode),
        .wb_data        (wb_data),
        .misaligned     (misaligned),
        .write_ok       (write_ok)
    );

    assign err_next   = bus.valid_in & misaligned;
    assign fault_addr = ADDR_W'(bus.result_in);
    assign dest_addr  = bus.reg_write_addr_in;

    // Flush only kills the control bits; stall clears addr_error so one fault never reports twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_out          <= 1'b0;
            bus.result_out         <= '0;
            bus.reg_write_en_out   <= 1'b0;
            bus.reg_write_addr_out <= '0;
            bus.debug_pc_addr_out  <= '0;
            bus.addr_error         <= 1'b0;
            bus.bad_addr           <= '0;
        end else if (bus.flush) begin
            bus.valid_out        <= 1'b0;
            bus.reg_write_en_out <= 1'b0;
            bus.addr_error       <= 1'b0;
        end else if (bus.stall) begin
            bus.addr_error <= 1'b0;
        end else begin
            bus.valid_out          <= bus.valid_in;
            bus.result_out         <= wb_data;
            bus.reg_write_en_out   <= bus.valid_in & bus.reg_write_en_in & write_ok;
            bus.reg_write_addr_out <= dest_addr;
            bus.debug_pc_addr_out  <= bus.current_pc_addr_in;
            bus.addr_error         <= err_next;
            if (err_next) bus.bad_addr <= fault_addr;
        end
    end

endmodule
